// File: rtl/beat_detector.sv
// beat_detector: peak-based beat detection on a signed sample stream.
// A sample above threshold starts a peak search, the first falling sample
// declares a beat, then a refractory window plus re-arm hysteresis blocks
// double counting. Emits beat strobe, peak amplitude and beat interval.
module beat_detector #(
    parameter int unsigned Width          = 10,
    parameter int unsigned CntWidth       = 12,
    parameter int unsigned RefractSamples = 50
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       valid_in,
    input  logic signed [Width-1:0]    data_in,
    input  logic signed [Width-1:0]    thresh_in,
    output logic                       beat_pulse,
    output logic signed [Width-1:0]    peak_out,
    output logic        [CntWidth-1:0] interval_out,
    output logic                       interval_valid
);

    localparam logic [CntWidth-1:0] CntMax      = '1;
    localparam logic [CntWidth-1:0] RefractLoad = CntWidth'(RefractSamples);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_RISING  = 2'd1,
        ST_REFRACT = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic        [CntWidth-1:0] cnt_q, cnt_d;
    logic        [CntWidth-1:0] rcnt_q, rcnt_d;
    logic signed [Width-1:0]    peak_reg_q, peak_reg_d;
    logic                       have_prev_q, have_prev_d;
    logic                       beat_pulse_q, beat_pulse_d;
    logic signed [Width-1:0]    peak_out_q, peak_out_d;
    logic        [CntWidth-1:0] interval_out_q, interval_out_d;
    logic                       interval_valid_q, interval_valid_d;

    logic                       acc_c;
    logic                       beat_c;
    logic        [CntWidth-1:0] cnt_next_c;

    // Accept strobe and saturating sample count including the current sample
    always_comb begin
        acc_c      = en && valid_in;
        cnt_next_c = (cnt_q == CntMax) ? CntMax : cnt_q + CntWidth'(1);
    end

    // Next-state logic: detection FSM, counters and beat report
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        rcnt_d           = rcnt_q;
        peak_reg_d       = peak_reg_q;
        have_prev_d      = have_prev_q;
        beat_pulse_d     = 1'b0;
        peak_out_d       = peak_out_q;
        interval_out_d   = interval_out_q;
        interval_valid_d = interval_valid_q;
        beat_c           = 1'b0;

        if (acc_c) begin
            cnt_d = cnt_next_c;
            unique case (state_q)
                ST_ARMED: begin
                    if (data_in > thresh_in) begin
                        state_d    = ST_RISING;
                        peak_reg_d = data_in;
                    end
                end
                ST_RISING: begin
                    // Plateaus keep searching; only a strictly lower sample ends the peak
                    if (data_in >= peak_reg_q) begin
                        peak_reg_d = data_in;
                    end else begin
                        beat_c  = 1'b1;
                        state_d = ST_REFRACT;
                        rcnt_d  = RefractLoad;
                    end
                end
                ST_REFRACT: begin
                    // Window expires first, then the signal must fall to threshold to re-arm
                    if (rcnt_q != '0) begin
                        rcnt_d = rcnt_q - CntWidth'(1);
                    end else if (data_in <= thresh_in) begin
                        state_d = ST_ARMED;
                    end
                end
                default: begin
                    state_d = ST_ARMED;
                end
            endcase

            if (beat_c) begin
                cnt_d            = '0;
                have_prev_d      = 1'b1;
                beat_pulse_d     = 1'b1;
                peak_out_d       = peak_reg_q;
                interval_out_d   = cnt_next_c;
                interval_valid_d = have_prev_q && (cnt_next_c != CntMax);
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_ARMED;
            cnt_q            <= '0;
            rcnt_q           <= '0;
            peak_reg_q       <= '0;
            have_prev_q      <= 1'b0;
            beat_pulse_q     <= 1'b0;
            peak_out_q       <= '0;
            interval_out_q   <= '0;
            interval_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            rcnt_q           <= rcnt_d;
            peak_reg_q       <= peak_reg_d;
            have_prev_q      <= have_prev_d;
            beat_pulse_q     <= beat_pulse_d;
            peak_out_q       <= peak_out_d;
            interval_out_q   <= interval_out_d;
            interval_valid_q <= interval_valid_d;
        end
    end

    assign beat_pulse     = beat_pulse_q;
    assign peak_out       = peak_out_q;
    assign interval_out   = interval_out_q;
    assign interval_valid = interval_valid_q;

endmodule

// File: tb/tb_beat_detector.sv
// Testbench for beat_detector: directed vector table plus hand-written
// reset and interval-saturation sequences.
module tb_beat_detector;

    localparam int unsigned W   = 10;
    localparam int unsigned CW  = 12;
    localparam int unsigned SCW = 4;
    localparam int unsigned R   = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic                 valid_in = 1'b0;
    logic signed [W-1:0]  data_in = '0;
    logic signed [W-1:0]  thresh_in = '0;

    logic                 beat_pulse;
    logic signed [W-1:0]  peak_out;
    logic [CW-1:0]        interval_out;
    logic                 interval_valid;

    logic                 s_beat_pulse;
    logic signed [W-1:0]  s_peak_out;
    logic [SCW-1:0]       s_interval_out;
    logic                 s_interval_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    beat_detector #(.Width(W), .CntWidth(CW), .RefractSamples(R)) dut (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in),
        .data_in(data_in), .thresh_in(thresh_in),
        .beat_pulse(beat_pulse), .peak_out(peak_out),
        .interval_out(interval_out), .interval_valid(interval_valid)
    );

    beat_detector #(.Width(W), .CntWidth(SCW), .RefractSamples(R)) dut_s (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in),
        .data_in(data_in), .thresh_in(thresh_in),
        .beat_pulse(s_beat_pulse), .peak_out(s_peak_out),
        .interval_out(s_interval_out), .interval_valid(s_interval_valid)
    );

    typedef struct {
        logic                r;
        logic                e;
        logic                v;
        logic signed [W-1:0] d;
        logic signed [W-1:0] t;
        logic                eb;
        logic signed [W-1:0] ep;
        logic [CW-1:0]       ei;
        logic                eiv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int r, input int e, input int v, input int d, input int t,
                       input int eb, input int ep, input int ei, input int eiv);
        vec_t x;
        x.r   = 1'(r);
        x.e   = 1'(e);
        x.v   = 1'(v);
        x.d   = W'(d);
        x.t   = W'(t);
        x.eb  = 1'(eb);
        x.ep  = W'(ep);
        x.ei  = CW'(ei);
        x.eiv = 1'(eiv);
        vecs.push_back(x);
    endtask

    // Apply one cycle of inputs and wait until just after the sampling edge
    task automatic drive(input logic r, input logic e, input logic v,
                         input logic signed [W-1:0] d, input logic signed [W-1:0] t);
        @(negedge clk);
        rst       = r;
        en        = e;
        valid_in  = v;
        data_in   = d;
        thresh_in = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] main_out();
        return 32'({beat_pulse, peak_out, interval_out, interval_valid});
    endfunction

    function automatic logic [31:0] sat_out();
        return 32'({s_beat_pulse, s_peak_out, s_interval_out, s_interval_valid});
    endfunction

    initial begin
        int beats_seen;

        // Segment A: first beat, refractory/hysteresis, refractory suppression
        add(0,1,1,   0,100, 0,  0,0,0);
        add(0,1,1, 120,100, 0,  0,0,0);
        add(0,1,1, 200,100, 0,  0,0,0);
        add(0,1,1, 180,100, 1,200,4,0);
        add(0,1,1, 150,100, 0,200,4,0);
        add(0,1,1, 150,100, 0,200,4,0);
        add(0,1,1, 150,100, 0,200,4,0);
        add(0,1,1, 150,100, 0,200,4,0);
        add(0,1,1,  50,100, 0,200,4,0);
        add(0,1,1,   0,100, 0,200,4,0);
        add(0,1,1, 130,100, 0,200,4,0);
        add(0,1,1, 140,100, 0,200,4,0);
        add(0,1,1,  90,100, 1,140,9,1);
        add(0,1,1, 300,100, 0,140,9,1);
        add(0,1,1,  20,100, 0,140,9,1);
        // Segment B: same stream with idle and disabled cycles inserted
        add(1,1,1, 300,100, 0,  0,0,0);
        add(0,1,1,   0,100, 0,  0,0,0);
        add(0,1,1, 120,100, 0,  0,0,0);
        add(0,1,0,  10,100, 0,  0,0,0);
        add(0,1,1, 200,100, 0,  0,0,0);
        for (int i = 0; i < 5; i++) add(0,0,1,500,100, 0,0,0,0);
        add(0,1,1, 180,100, 1,200,4,0);
        add(0,1,1, 150,100, 0,200,4,0);
        add(0,1,0,   0,100, 0,200,4,0);
        add(0,1,1, 150,100, 0,200,4,0);
        add(0,1,1, 150,100, 0,200,4,0);
        for (int i = 0; i < 5; i++) add(0,0,1,20,100, 0,200,4,0);
        add(0,1,1, 150,100, 0,200,4,0);
        add(0,1,1,  50,100, 0,200,4,0);
        add(0,1,1,   0,100, 0,200,4,0);
        add(0,1,1, 130,100, 0,200,4,0);
        add(0,1,1, 140,100, 0,200,4,0);
        add(0,1,0,  10,100, 0,200,4,0);
        add(0,1,1,  90,100, 1,140,9,1);
        add(0,1,0,   0,100, 0,140,9,1);
        // Segment C: threshold drop during peak search, then reset on the pulse cycle
        add(1,1,1,   0,100, 0,  0,0,0);
        add(0,1,1, 120,100, 0,  0,0,0);
        add(0,1,1, 130,-50, 0,  0,0,0);
        add(0,1,1, 130,100, 0,  0,0,0);
        add(0,1,1, 125,100, 1,130,4,0);
        add(1,1,1,  50,100, 0,  0,0,0);
        // Segment D: have_prev cleared by reset, fastest re-arm spacing
        add(0,1,1, 120,100, 0,  0,0,0);
        add(0,1,1, 110,100, 1,120,2,0);
        add(0,1,1,   0,100, 0,120,2,0);
        add(0,1,1,   0,100, 0,120,2,0);
        add(0,1,1,   0,100, 0,120,2,0);
        add(0,1,1,   0,100, 0,120,2,0);
        add(0,1,1, 120,100, 0,120,2,0);
        add(0,1,1, 110,100, 1,120,6,1);
        // Segment E: signed comparisons around a negative threshold
        add(1,1,1,   0,-20, 0,  0,0,0);
        add(0,1,1, -30,-20, 0,  0,0,0);
        add(0,1,1,   5,-20, 0,  0,0,0);
        add(0,1,1,  -3,-20, 1,  5,3,0);

        // Reset held three cycles with random stimulus
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
            check($sformatf("reset_%0d", i), main_out(), 32'd0);
        end
        check("reset_sat", sat_out(), 32'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].e, vecs[i].v, vecs[i].d, vecs[i].t);
            check($sformatf("vec%0d", i), main_out(),
                  32'({vecs[i].eb, vecs[i].ep, vecs[i].ei, vecs[i].eiv}));
        end

        // Interval saturation on the narrow-counter instance
        drive(1'b1, 1'b1, 1'b1, W'(0), W'(100));
        drive(1'b0, 1'b1, 1'b1, W'(120), W'(100));
        drive(1'b0, 1'b1, 1'b1, W'(110), W'(100));
        check("sat_first_beat", sat_out(), 32'({1'b1, W'(120), SCW'(2), 1'b0}));
        beats_seen = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b1, W'(20), W'(100));
            if (s_beat_pulse) beats_seen++;
        end
        check("sat_no_beat_below_thresh", 32'(beats_seen), 32'd0);
        drive(1'b0, 1'b1, 1'b1, W'(120), W'(100));
        drive(1'b0, 1'b1, 1'b1, W'(200), W'(100));
        drive(1'b0, 1'b1, 1'b1, W'(180), W'(100));
        check("sat_beat", sat_out(), 32'({1'b1, W'(200), SCW'(15), 1'b0}));
        drive(1'b0, 1'b1, 1'b0, W'(0), W'(100));
        check("sat_hold", sat_out(), 32'({1'b0, W'(200), SCW'(15), 1'b0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
